// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants
// for the buffered UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL = 1'b1;

  function automatic int bit_cyc(
    input int half
  );
    return 2 * half;
  endfunction

  function automatic int timer_w(
    input int half
  );
    return $clog2(2 * half);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with count,
// first-word-fall-through dout and sticky overflow.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0] count;
  logic push;
  logic pop;

  assign full = count == FULL_CNT;
  assign empty = count == '0;
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  assign dout = mem[rd_ptr];

  // Storage array; no reset needed, count gates validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full) overflow <= 1'b1;
      unique case ({push, pop})
        2'b10: count <= count + 1'b1;
        2'b01: count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-fed 8N1 serializer,
// LSB first, back-to-back frames without gap.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int FIFO_AW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       txd
);

  localparam int BIT_CYC = bit_cyc(CLK_PER_HALF_BIT);
  localparam int TW = timer_w(CLK_PER_HALF_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(BIT_CYC - 1);
  localparam logic [2:0] I_LAST = 3'(DATA_BITS - 1);

  tx_state_t state;
  logic [TW-1:0] timer;
  logic [2:0] idx;
  logic [7:0] shift;
  logic [7:0] head;
  logic txd_q;
  logic last;
  logic pop;

  assign last = timer == T_LAST;
  assign pop = !empty &&
    ((state == IDLE) || (state == STOP && last));
  assign busy = (state != IDLE) || !empty;
  assign txd = txd_q;

  sync_fifo #(
    .WIDTH(8),
    .AW(FIFO_AW)
  ) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .din(din),
    .rd_en(pop),
    .dout(head),
    .full(full),
    .empty(empty),
    .overflow(overflow)
  );

  // Frame sequencer: timer paces bits, txd leaves a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      idx <= '0;
      shift <= '0;
      txd_q <= STOP_LVL;
    end else begin
      unique case (state)
        IDLE: begin
          timer <= '0;
          if (!empty) begin
            shift <= head;
            state <= START;
            txd_q <= START_LVL;
          end
        end
        START: begin
          if (last) begin
            timer <= '0;
            idx <= '0;
            state <= DATA;
            txd_q <= shift[0];
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (last) begin
            timer <= '0;
            if (idx == I_LAST) begin
              state <= STOP;
              txd_q <= STOP_LVL;
            end else begin
              idx <= idx + 1'b1;
              shift <= shift >> 1;
              txd_q <= shift[1];
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (last) begin
            timer <= '0;
            if (!empty) begin
              shift <= head;
              state <= START;
              txd_q <= START_LVL;
            end else begin
              state <= IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
